// File: rtl/sv_uart_rx_engine_if.sv
// Word-stream handshake bundle for the UART receive engine.
// The master drives tdata/tvalid and the slave drives tready.
interface sv_uart_rx_engine_if #(
    parameter int DATA_WIDTH = 24
) ();
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tready;

    modport master (output tdata, output tvalid, input tready);
    modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/sv_uart_rx_engine.sv
// 8N1 UART receiver that packs WORDS_NUM bytes, first byte most significant, into one stream word.
// Reports framing, inter-byte timeout and overrun events as single-cycle pulses.
module sv_uart_rx_engine #(
    parameter int DATA_WIDTH   = 24,
    parameter int RX_PIPE      = 5,
    parameter int TIMEOUT_BITS = 20
) (
    input  logic                       iclk,
    input  logic                       irst,
    input  logic                       irx,
    input  logic [15:0]                idivider,
    sv_uart_rx_engine_if.master        m_axis,
    output logic                       oframe_err,
    output logic                       otimeout,
    output logic                       ooverrun
);
    localparam int WORDS_NUM = DATA_WIDTH / 8;
    localparam int CNT_W     = $clog2(WORDS_NUM + 1);
    localparam int TO_W      = $clog2(TIMEOUT_BITS + 1);
    localparam logic [CNT_W-1:0] LAST_BYTE   = CNT_W'(WORDS_NUM - 1);
    localparam logic [TO_W-1:0]  LAST_PERIOD = TO_W'(TIMEOUT_BITS - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK_WAIT} state_t;

    state_t                  state;
    logic [RX_PIPE-1:0]      sync_q;
    logic                    rxs;
    logic [15:0]             d_eff;
    logic [15:0]             div_q;
    logic [15:0]             timer;
    logic [2:0]              bit_cnt;
    logic [7:0]              byte_sr;
    logic [DATA_WIDTH-9:0]   word_sr;
    logic [CNT_W-1:0]        byte_cnt;
    logic [15:0]             to_cyc;
    logic [TO_W-1:0]         to_bits;
    logic                    word_done;
    logic [DATA_WIDTH-1:0]   next_word;

    // Synchroniser resets to the idle (high) line level so reset never looks like a start bit.
    always_ff @(posedge iclk) begin
        if (irst) sync_q <= '1;
        else      sync_q <= {sync_q[RX_PIPE-2:0], irx};
    end

    assign rxs       = sync_q[RX_PIPE-1];
    assign d_eff     = (idivider < 16'd4) ? 16'd4 : idivider;
    assign next_word = {word_sr, byte_sr};
    assign word_done = (state == STOP) && (timer == 16'd0) && rxs && (byte_cnt == LAST_BYTE);

    // NOTE: all sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge iclk) begin
        if (irst) begin
            state      <= IDLE;
            div_q      <= '0;
            timer      <= '0;
            bit_cnt    <= '0;
            byte_sr    <= '0;
            word_sr    <= '0;
            byte_cnt   <= '0;
            to_cyc     <= '0;
            to_bits    <= '0;
            oframe_err <= 1'b0;
            otimeout   <= 1'b0;
        end else begin
            oframe_err <= 1'b0;
            otimeout   <= 1'b0;
            case (state)
                IDLE: begin
                    // A start edge takes priority over a timeout expiring in the same cycle.
                    if (!rxs) begin
                        state   <= START;
                        div_q   <= d_eff;
                        timer   <= (d_eff >> 1) - 16'd1;
                        to_cyc  <= '0;
                        to_bits <= '0;
                    end else if (byte_cnt != '0) begin
                        if (to_cyc >= div_q - 16'd1) begin
                            to_cyc <= '0;
                            if (to_bits == LAST_PERIOD) begin
                                otimeout <= 1'b1;
                                byte_cnt <= '0;
                                to_bits  <= '0;
                            end else begin
                                to_bits <= to_bits + 1'b1;
                            end
                        end else begin
                            to_cyc <= to_cyc + 16'd1;
                        end
                    end
                end
                START: begin
                    if (timer == 16'd0) begin
                        if (!rxs) begin
                            state   <= DATA;
                            timer   <= div_q - 16'd1;
                            bit_cnt <= '0;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        timer <= timer - 16'd1;
                    end
                end
                DATA: begin
                    if (timer == 16'd0) begin
                        byte_sr <= {rxs, byte_sr[7:1]};
                        timer   <= div_q - 16'd1;
                        if (bit_cnt == 3'd7) state <= STOP;
                        else                 bit_cnt <= bit_cnt + 3'd1;
                    end else begin
                        timer <= timer - 16'd1;
                    end
                end
                STOP: begin
                    if (timer == 16'd0) begin
                        if (rxs) begin
                            word_sr  <= next_word[DATA_WIDTH-9:0];
                            byte_cnt <= (byte_cnt == LAST_BYTE) ? '0 : byte_cnt + 1'b1;
                            state    <= IDLE;
                        end else begin
                            oframe_err <= 1'b1;
                            byte_cnt   <= '0;
                            state      <= BREAK_WAIT;
                        end
                    end else begin
                        timer <= timer - 16'd1;
                    end
                end
                BREAK_WAIT: begin
                    if (rxs) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Output holding register; a completed word is dropped rather than overwriting an unaccepted one.
    always_ff @(posedge iclk) begin
        if (irst) begin
            m_axis.tdata  <= '0;
            m_axis.tvalid <= 1'b0;
            ooverrun      <= 1'b0;
        end else begin
            ooverrun <= 1'b0;
            if (word_done) begin
                if (!m_axis.tvalid || m_axis.tready) begin
                    m_axis.tdata  <= next_word;
                    m_axis.tvalid <= 1'b1;
                end else begin
                    ooverrun <= 1'b1;
                end
            end else if (m_axis.tvalid && m_axis.tready) begin
                m_axis.tvalid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_sv_uart_rx_engine.sv
// Directed bench for sv_uart_rx_engine: serial stimulus with a queued scoreboard and an independent beat monitor.
// Event pulses are counted separately and compared against hand-computed totals.
module tb_sv_uart_rx_engine;
    localparam int DW   = 24;
    localparam int PIPE = 5;
    localparam int TOB  = 20;
    localparam int DIV  = 16;
    localparam int LAT  = PIPE + DIV / 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx;
    logic [15:0] divider;
    logic        frame_err, timeout, overrun;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fe = 0, n_to = 0, n_ov = 0;
    logic [DW-1:0] exp_q[$];

    sv_uart_rx_engine_if #(.DATA_WIDTH(DW)) axis ();

    sv_uart_rx_engine #(
        .DATA_WIDTH  (DW),
        .RX_PIPE     (PIPE),
        .TIMEOUT_BITS(TOB)
    ) dut (
        .iclk      (clk),
        .irst      (rst),
        .irx       (rx),
        .idivider  (divider),
        .m_axis    (axis),
        .oframe_err(frame_err),
        .otimeout  (timeout),
        .ooverrun  (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Beat monitor: every handshake must match the oldest expected word.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (!rst && axis.tvalid === 1'b1 && axis.tready === 1'b1) begin
                if (exp_q.size() == 0) check("unexpected_beat_queue_size", 32'(exp_q.size()), 32'd1);
                else                   check("beat_tdata", 32'(axis.tdata), 32'(exp_q.pop_front()));
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (frame_err) n_fe++;
            if (timeout)   n_to++;
            if (overrun)   n_ov++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] data, input logic stop_val, input bit chk_lat);
        rx = 1'b0;
        repeat (DIV) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = data[i];
            repeat (DIV) @(negedge clk);
        end
        rx = stop_val;
        if (chk_lat) begin
            repeat (LAT) @(negedge clk);
            check("tvalid_low_at_stop_sample", 32'(axis.tvalid), 32'd0);
            @(negedge clk);
            check("tvalid_one_cycle_after_stop_sample", 32'(axis.tvalid), 32'd1);
            repeat (DIV - LAT - 1) @(negedge clk);
        end else begin
            repeat (DIV) @(negedge clk);
        end
        rx = 1'b1;
    endtask

    task automatic send_word(input logic [DW-1:0] w);
        for (int b = 0; b < DW / 8; b++) send_byte(w[DW-1-8*b -: 8], 1'b1, 1'b0);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 4000 && exp_q.size() != 0; i++) @(negedge clk);
        check(name, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_counts(input string name, input int fe, input int to, input int ov);
        check({name, "_frame_err_count"}, 32'(n_fe), 32'(fe));
        check({name, "_timeout_count"},   32'(n_to), 32'(to));
        check({name, "_overrun_count"},   32'(n_ov), 32'(ov));
    endtask

    initial begin
        rx          = 1'b1;
        divider     = 16'(DIV);
        axis.tready = 1'b1;
        rst         = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_tdata",     32'(axis.tdata), 32'd0);
        check("reset_tvalid",    32'(axis.tvalid), 32'd0);
        check("reset_frame_err", 32'(frame_err), 32'd0);
        check("reset_timeout",   32'(timeout), 32'd0);
        check("reset_overrun",   32'(overrun), 32'd0);
        rst = 1'b0;
        idle(2 * DIV);

        // 1: back-to-back bytes form one word; latency checked on the last stop bit.
        exp_q.push_back(24'hA53C7E);
        send_byte(8'hA5, 1'b1, 1'b0);
        send_byte(8'h3C, 1'b1, 1'b0);
        send_byte(8'h7E, 1'b1, 1'b1);
        idle(4 * DIV);
        drain("t1_drain");
        check_counts("t1", 0, 0, 0);

        // 2: second word dropped while the first is held.
        axis.tready = 1'b0;
        send_word(24'h010203);
        send_word(24'h040506);
        idle(2 * DIV);
        check("t2_held_tdata",  32'(axis.tdata), 32'h010203);
        check("t2_held_tvalid", 32'(axis.tvalid), 32'd1);
        check_counts("t2", 0, 0, 1);
        exp_q.push_back(24'h010203);
        axis.tready = 1'b1;
        drain("t2_drain");
        idle(4 * DIV);
        check("t2_tvalid_after_beat", 32'(axis.tvalid), 32'd0);

        // 3: framing error discards the bad byte.
        send_byte(8'h11, 1'b0, 1'b0);
        idle(3 * DIV);
        exp_q.push_back(24'h223344);
        send_word(24'h223344);
        idle(2 * DIV);
        drain("t3_drain");
        check_counts("t3", 1, 0, 1);

        // 4: inter-byte timeout drops a partial word.
        send_byte(8'hAA, 1'b1, 1'b0);
        send_byte(8'hBB, 1'b1, 1'b0);
        idle(25 * DIV);
        check_counts("t4_after_idle", 1, 1, 1);
        exp_q.push_back(24'hCCDDEE);
        send_word(24'hCCDDEE);
        idle(2 * DIV);
        drain("t4_drain");

        // 5: short low glitch is a false start.
        rx = 1'b0;
        repeat (5) @(negedge clk);
        idle(3 * DIV);
        check("t5_tvalid_after_glitch", 32'(axis.tvalid), 32'd0);
        check_counts("t5_after_glitch", 1, 1, 1);
        exp_q.push_back(24'h5A6996);
        send_word(24'h5A6996);
        idle(2 * DIV);
        drain("t5_drain");

        // 6: reset in the middle of the second byte discards the partial word.
        send_byte(8'h77, 1'b1, 1'b0);
        rx = 1'b0;
        repeat (DIV) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx = i[0];
            repeat (DIV) @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        check("t6_reset_tdata",     32'(axis.tdata), 32'd0);
        check("t6_reset_tvalid",    32'(axis.tvalid), 32'd0);
        check("t6_reset_frame_err", 32'(frame_err), 32'd0);
        check("t6_reset_overrun",   32'(overrun), 32'd0);
        rst = 1'b0;
        idle(12 * DIV);
        check("t6_tvalid_after_reset", 32'(axis.tvalid), 32'd0);
        exp_q.push_back(24'h0A0B0C);
        send_word(24'h0A0B0C);
        idle(2 * DIV);
        drain("t6_drain");
        check_counts("final", 1, 1, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
